mips_cpu_alu: RTL and testbench

MIPS_CPU_ALU -- requirements
Module: mips_cpu_alu

---
 rtl/mips_cpu_alu.sv | 83 ++++++++
 tb/tb_mips_cpu_alu.sv | 97 +++++++++
 2 files changed

// File: rtl/mips_cpu_alu.sv
// Single-cycle MIPS ALU with a registered result and a zero flag derived from it.
// Variable shifts (SLLV/SRLV/SRAV) are built only when MIPS_CPU_ALU_VARSHIFT_EN is defined.
module mips_cpu_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            control,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [4:0]            sa,
  output logic [DATA_WIDTH-1:0] r,
  output logic                  zero
);

  typedef enum logic [3:0] {
    opAnd  = 4'b0000,
    opOr   = 4'b0001,
    opXor  = 4'b0010,
    opNor  = 4'b0011,
    opAdd  = 4'b0100,
    opSub  = 4'b0101,
    opSlt  = 4'b0110,
    opSltu = 4'b0111,
    opSll  = 4'b1000,
    opSrl  = 4'b1001,
    opSra  = 4'b1010,
    opSllv = 4'b1011,
    opSrlv = 4'b1100,
    opSrav = 4'b1101,
    opLui  = 4'b1110,
    opNone = 4'b1111
  } aluOp_t;

  aluOp_t                op;
  logic [DATA_WIDTH-1:0] result;
  logic [4:0]            varAmt;
  logic                  ltSigned;
  logic                  ltUnsigned;

  assign op         = aluOp_t'(control);
  assign varAmt     = a[4:0];
  assign ltSigned   = $signed(a) < $signed(b);
  assign ltUnsigned = a < b;

  // Add/sub wrap modulo 2^32; there is intentionally no overflow output.
  always_comb begin
    result = '0;
    unique case (op)
      opAnd:  result = a & b;
      opOr:   result = a | b;
      opXor:  result = a ^ b;
      opNor:  result = ~(a | b);
      opAdd:  result = a + b;
      opSub:  result = a - b;
      opSlt:  result = {{(DATA_WIDTH-1){1'b0}}, ltSigned};
      opSltu: result = {{(DATA_WIDTH-1){1'b0}}, ltUnsigned};
      opSll:  result = b << sa;
      opSrl:  result = b >> sa;
      opSra:  result = $unsigned($signed(b) >>> sa);
`ifdef MIPS_CPU_ALU_VARSHIFT_EN
      opSllv: result = b << varAmt;
      opSrlv: result = b >> varAmt;
      opSrav: result = $unsigned($signed(b) >>> varAmt);
`else
      opSllv: result = '0;
      opSrlv: result = '0;
      opSrav: result = '0;
`endif
      opLui:  result = {b[15:0], 16'h0000};
      opNone: result = '0;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r <= '0;
    else        r <= result;
  end

  assign zero = (r == '0);

endmodule

// File: tb/tb_mips_cpu_alu.sv
// Directed-vector bench for mips_cpu_alu; expected values are hand-computed.
module tb_mips_cpu_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  control;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  sa;
  logic [31:0] r;
  logic        zero;

  int compared   = 0;
  int mismatched = 0;

  mips_cpu_alu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .control(control),
    .a(a), .b(b), .sa(sa), .r(r), .zero(zero)
  );

  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then observe 1 ns after the rising edge.
  task automatic step(input logic rst, input logic [3:0] ctl, input logic [31:0] av,
                      input logic [31:0] bv, input logic [4:0] sav);
    @(negedge clk);
    reset = rst; control = ctl; a = av; b = bv; sa = sav;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] expR);
    logic expZ;
    expZ = (expR == 32'h0);
    compared++;
    assert (r === expR) else begin
      mismatched++;
      $error("FAIL %s: r observed %h expected %h", tag, r, expR);
    end
    compared++;
    assert (zero === expZ) else begin
      mismatched++;
      $error("FAIL %s.zero: observed %b expected %b", tag, zero, expZ);
    end
  endtask

  initial begin
    reset = 1'b0; control = 4'b0000; a = '0; b = '0; sa = '0;

    step(1'b0, 4'b0100, 32'd5, 32'd7, 5'd0);                check("reset", 32'h0);
    step(1'b1, 4'b0100, 32'd5, 32'd7, 5'd0);                check("add_after_reset", 32'd12);

    step(1'b1, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3); check("and", 32'h00F0_1200);
    step(1'b1, 4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3); check("or",  32'hFFF0_FF34);
    step(1'b1, 4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3); check("xor", 32'hFF00_ED34);
    step(1'b1, 4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3); check("nor", 32'h000F_00CB);

    step(1'b1, 4'b0100, 32'hFFFF_FFFF, 32'h1, 5'd31);       check("add_wrap", 32'h0);
    step(1'b1, 4'b0100, 32'hBFC0_0000, 32'hFFFF_FFFC, 5'd0); check("add_neg_imm", 32'hBFBF_FFFC);
    step(1'b1, 4'b0101, 32'd3, 32'd5, 5'd0);                check("sub_wrap", 32'hFFFF_FFFE);
    step(1'b1, 4'b0101, 32'h1234_5678, 32'h1234_5678, 5'd0); check("sub_equal", 32'h0);

    step(1'b1, 4'b0110, 32'hFFFF_FFFF, 32'h1, 5'd0);        check("slt", 32'h1);
    step(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0);        check("sltu", 32'h0);
    step(1'b1, 4'b0110, 32'h7, 32'h7, 5'd0);                check("slt_equal", 32'h0);
    step(1'b1, 4'b0111, 32'h1, 32'hFFFF_FFFF, 5'd0);        check("sltu_lt", 32'h1);

    step(1'b1, 4'b1010, 32'h0, 32'h8000_0000, 5'd31);       check("sra31", 32'hFFFF_FFFF);
    step(1'b1, 4'b1001, 32'h0, 32'h8000_0000, 5'd31);       check("srl31", 32'h1);
    step(1'b1, 4'b1000, 32'h0, 32'h1, 5'd31);               check("sll31", 32'h8000_0000);
    step(1'b1, 4'b1010, 32'h0, 32'h8000_0000, 5'd0);        check("sra0", 32'h8000_0000);
    step(1'b1, 4'b1000, 32'h1F, 32'hDEAD_BEEF, 5'd0);       check("sll0", 32'hDEAD_BEEF);
    step(1'b1, 4'b1010, 32'h0, 32'hF000_0000, 5'd4);        check("sra4", 32'hFF00_0000);

`ifdef MIPS_CPU_ALU_VARSHIFT_EN
    step(1'b1, 4'b1101, 32'd4, 32'hF000_0000, 5'd0);        check("srav", 32'hFF00_0000);
    step(1'b1, 4'b1100, 32'd36, 32'hF000_0000, 5'd9);       check("srlv", 32'h0F00_0000);
    step(1'b1, 4'b1011, 32'hFFFF_FFE4, 32'h1, 5'd0);        check("sllv", 32'h10);
`else
    step(1'b1, 4'b1101, 32'd4, 32'hF000_0000, 5'd0);        check("srav_off", 32'h0);
    step(1'b1, 4'b1100, 32'd36, 32'hF000_0000, 5'd9);       check("srlv_off", 32'h0);
    step(1'b1, 4'b1011, 32'hFFFF_FFE4, 32'h1, 5'd0);        check("sllv_off", 32'h0);
`endif

    step(1'b1, 4'b1110, 32'h0, 32'h0000_1234, 5'd0);        check("lui", 32'h1234_0000);
    step(1'b1, 4'b1110, 32'h0, 32'hFFFF_1234, 5'd7);        check("lui_hi_ignored", 32'h1234_0000);
    step(1'b1, 4'b1111, 32'hFFFF_FFFF, 32'h0000_1234, 5'd3); check("default", 32'h0);

    step(1'b1, 4'b0100, 32'd100, 32'd23, 5'd0);             check("add_pre_reset", 32'd123);
    step(1'b0, 4'b0100, 32'd100, 32'd23, 5'd0);             check("reset_mid_op", 32'h0);
    step(1'b1, 4'b0001, 32'h0000_00A0, 32'h0000_000B, 5'd0); check("resume_or", 32'h0000_00AB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
